// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer:
// phase codes, mode and timer-state enums, and the per-mode/per-phase
// duration table used both for loading the timer and for display.
package washer_pkg;

  localparam logic [1:0] PH_SOAK  = 2'b00;
  localparam logic [1:0] PH_WASH  = 2'b01;
  localparam logic [1:0] PH_RINSE = 2'b10;
  localparam logic [1:0] PH_SPIN  = 2'b11;

  localparam int DUR_W = 8;

  typedef enum logic [1:0] {
    MODE_LIGHT  = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_HEAVY  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  // mode1 beats mode2 beats mode3; no selection falls back to normal.
  function automatic mode_e mode_resolve(input logic m1, input logic m2, input logic m3);
    mode_e m;
    m = MODE_NORMAL;
    if (m1)      m = MODE_LIGHT;
    else if (m2) m = MODE_NORMAL;
    else if (m3) m = MODE_HEAVY;
    return m;
  endfunction

  // Phase duration in ticks for a given wash mode.
  function automatic logic [DUR_W-1:0] dur_lookup(input mode_e mode, input logic [1:0] phase);
    logic [DUR_W-1:0] d;
    d = 8'd10;
    case (mode)
      MODE_LIGHT: begin
        case (phase)
          PH_SOAK:  d = 8'd5;
          PH_WASH:  d = 8'd10;
          PH_RINSE: d = 8'd5;
          default:  d = 8'd5;
        endcase
      end
      MODE_HEAVY: begin
        case (phase)
          PH_SOAK:  d = 8'd20;
          PH_WASH:  d = 8'd40;
          PH_RINSE: d = 8'd20;
          default:  d = 8'd15;
        endcase
      end
      default: begin
        case (phase)
          PH_SOAK:  d = 8'd10;
          PH_WASH:  d = 8'd20;
          PH_RINSE: d = 8'd10;
          default:  d = 8'd10;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/washer_phase_timer_if.sv
// Controller <-> phase-timer link. The controller FSM is the master: it
// drives enable, phase, mode and lid, and receives done/remaining/running.
interface washer_phase_timer_if #(
  parameter int CNT_W = 8
) ();

  logic             timer_enable;
  logic [1:0]       phase_sel;
  logic             mode1;
  logic             mode2;
  logic             mode3;
  logic             lid;
  logic             timer_done;
  logic [CNT_W-1:0] remaining;
  logic             running;

  modport master (
    output timer_enable, phase_sel, mode1, mode2, mode3, lid,
    input  timer_done, remaining, running
  );

  modport slave (
    input  timer_enable, phase_sel, mode1, mode2, mode3, lid,
    output timer_done, remaining, running
  );

endinterface

// File: rtl/washer_tick_prescaler.sv
// Divides clk into one-cycle ticks: counts 0..TICK_DIV-1 while enabled and
// pulses tick on the wrap cycle. clr forces the count back to zero and wins
// over en. TICK_DIV must be at least 2.
module washer_tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear, hold, increment or wrap.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/washer_phase_timer.sv
// Phase-duration timer for the washing-machine controller. Loads the
// duration for the latched mode and the requested phase, counts it down in
// prescaler ticks and returns a one-cycle timer_done so the controller can
// advance to the next phase. remaining is exported for the display.
//
// Build option WASHER_TIMER_LID_PAUSE_EN: when defined, an open lid freezes
// the countdown in RUN; when undefined the lid input is ignored.
module washer_phase_timer
  import washer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  washer_phase_timer_if.slave  tif
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  mode_e            mode_q, mode_d;
  logic [1:0]       prev_phase_q, prev_phase_d;
  logic             done_q, done_d;

  logic             pause;
  logic             psc_en;
  logic             psc_clr;
  logic             tick;
  mode_e            load_mode;
  logic [CNT_W-1:0] load_val;

`ifdef WASHER_TIMER_LID_PAUSE_EN
  assign pause = tif.lid;
`else
  logic lid_unused;
  assign lid_unused = tif.lid;
  assign pause      = 1'b0;
`endif

  assign psc_en = (state_q == ST_RUN) && !pause;

  washer_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (psc_clr),
    .en    (psc_en),
    .tick  (tick)
  );

  // Load value: mode comes from the inputs only on the IDLE->RUN load,
  // otherwise from the latched copy; a zero duration is stretched to one tick.
  always_comb begin
    load_mode = (state_q == ST_IDLE) ? mode_resolve(tif.mode1, tif.mode2, tif.mode3) : mode_q;
    load_val  = CNT_W'(dur_lookup(load_mode, tif.phase_sel));
    if (load_val == '0) load_val = CNT_W'(1);
  end

  // Next-state logic: load, countdown, expiry, reload on phase change, cancel.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    mode_d       = mode_q;
    prev_phase_d = prev_phase_q;
    done_d       = 1'b0;
    psc_clr      = (state_q != ST_RUN);

    unique case (state_q)
      ST_IDLE: begin
        if (tif.timer_enable) begin
          remaining_d  = load_val;
          mode_d       = load_mode;
          prev_phase_d = tif.phase_sel;
          psc_clr      = 1'b1;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!tif.timer_enable) begin
          // Cancel outranks a same-cycle expiry: no done pulse.
          remaining_d = '0;
          psc_clr     = 1'b1;
          state_d     = ST_IDLE;
        end else if (tif.phase_sel != prev_phase_q) begin
          remaining_d  = load_val;
          prev_phase_d = tif.phase_sel;
          psc_clr      = 1'b1;
        end else if (tick) begin
          if (remaining_q <= CNT_W'(1)) begin
            remaining_d = '0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (!tif.timer_enable) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end else if (tif.phase_sel != prev_phase_q) begin
          remaining_d  = load_val;
          prev_phase_d = tif.phase_sel;
          psc_clr      = 1'b1;
          state_d      = ST_RUN;
        end
      end

      default: begin
        remaining_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      mode_q       <= MODE_LIGHT;
      prev_phase_q <= PH_SOAK;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      mode_q       <= mode_d;
      prev_phase_q <= prev_phase_d;
      done_q       <= done_d;
    end
  end

  // Done is additionally qualified by enable so it can never show while the
  // controller has already dropped the request.
  assign tif.timer_done = done_q && tif.timer_enable;
  assign tif.remaining  = remaining_q;
  assign tif.running    = (state_q == ST_RUN) && !pause;

endmodule

// File: tb/tb_washer_phase_timer.sv
// Directed bench for washer_phase_timer with TICK_DIV=4. Each load pushes the
// cycle at which timer_done must appear; a monitor records the cycles where
// it actually appears, and the sequence pops and compares the two.
module tb_washer_phase_timer;
  import washer_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 8;

`ifdef WASHER_TIMER_LID_PAUSE_EN
  localparam int   LID_DELAY      = 7;
  localparam logic LID_RUNNING    = 1'b0;
  localparam int   LID_FROZEN_REM = 4;
`else
  localparam int   LID_DELAY      = 0;
  localparam logic LID_RUNNING    = 1'b1;
  localparam int   LID_FROZEN_REM = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];
  int   done_seen[$];
  logic prev_done = 1'b0;

  washer_phase_timer_if #(.CNT_W(CNT_W)) tif ();

  washer_phase_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Record every done pulse with its cycle number; a pulse must never follow
  // another pulse directly and never appear with enable low.
  always @(posedge clk) begin
    #1;
    if (tif.timer_done === 1'b1) begin
      done_seen.push_back(cyc);
      check("done_not_back_to_back", {31'd0, prev_done}, 0);
      check("done_with_enable", {31'd0, tif.timer_enable}, 1);
    end
    prev_done <= tif.timer_done;
  end

  task automatic wait_done(input string tag, input int budget);
    int n;
    int obs;
    int exp;
    n = 0;
    while (done_seen.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, (done_seen.size() > 0) ? 32'd1 : 32'd0, 1);
    if (done_seen.size() > 0) begin
      obs = done_seen.pop_front();
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else                  exp = -1;
      check({tag, "_cycle"}, obs, exp);
    end
  endtask

  initial begin
    tif.timer_enable = 1'b0;
    tif.phase_sel    = PH_SOAK;
    tif.mode1        = 1'b0;
    tif.mode2        = 1'b0;
    tif.mode3        = 1'b0;
    tif.lid          = 1'b0;
    rst_n            = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_remaining", tif.remaining, 0);
    check("rst_running", tif.running, 0);
    check("rst_done", tif.timer_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_running", tif.running, 0);

    // Light soak: load 5, tick every 4 cycles, done 20 cycles after load.
    tif.mode1        = 1'b1;
    tif.phase_sel    = PH_SOAK;
    tif.timer_enable = 1'b1;
    exp_q.push_back(cyc + 1 + 5 * TICK_DIV);
    @(negedge clk);
    check("t1_load_remaining", tif.remaining, 5);
    check("t1_running", tif.running, 1);
    repeat (4) @(negedge clk);
    check("t1_first_tick", tif.remaining, 4);
    wait_done("t1_done", 100);
    check("t1_done_remaining", tif.remaining, 0);
    check("t1_done_running", tif.running, 0);
    @(negedge clk);
    check("t1_done_single", tif.timer_done, 0);
    check("t1_hold_remaining", tif.remaining, 0);

    // Phase change out of DONE reloads light wash (10 ticks).
    tif.phase_sel = PH_WASH;
    exp_q.push_back(cyc + 1 + 10 * TICK_DIV);
    @(negedge clk);
    check("t2_reload", tif.remaining, 10);
    check("t2_running", tif.running, 1);
    wait_done("t2_done", 100);
    tif.timer_enable = 1'b0;
    tif.mode1        = 1'b0;
    @(negedge clk);
    check("t2_idle_remaining", tif.remaining, 0);
    check("t2_idle_running", tif.running, 0);

    // No mode bit: normal spin (10). mode3 raised mid-run must not change
    // the latched mode, so the following soak reload is normal (10), not heavy.
    tif.phase_sel    = PH_SPIN;
    tif.timer_enable = 1'b1;
    exp_q.push_back(cyc + 1 + 10 * TICK_DIV);
    @(negedge clk);
    check("t3_load", tif.remaining, 10);
    repeat (6) @(negedge clk);
    tif.mode3 = 1'b1;
    wait_done("t3_done", 100);
    tif.phase_sel = PH_SOAK;
    exp_q.push_back(cyc + 1 + 10 * TICK_DIV);
    @(negedge clk);
    check("t3_mode_kept", tif.remaining, 10);
    wait_done("t3_done2", 100);
    tif.timer_enable = 1'b0;
    tif.mode3        = 1'b0;
    @(negedge clk);

    // Cancel race: enable drops in the cycle of the final tick; no done.
    tif.mode1        = 1'b1;
    tif.phase_sel    = PH_SOAK;
    tif.timer_enable = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_pre_expiry", tif.remaining, 1);
    tif.timer_enable = 1'b0;
    @(negedge clk);
    check("t4_remaining", tif.remaining, 0);
    check("t4_running", tif.running, 0);
    check("t4_done", tif.timer_done, 0);
    @(negedge clk);
    check("t4_no_done", done_seen.size(), 0);

    // Lid open for 7 cycles mid-run.
    tif.timer_enable = 1'b1;
    exp_q.push_back(cyc + 1 + 5 * TICK_DIV + LID_DELAY);
    repeat (6) @(negedge clk);
    tif.lid = 1'b1;
    @(negedge clk);
    check("t5_lid_running", tif.running, LID_RUNNING);
    repeat (6) @(negedge clk);
    check("t5_lid_remaining", tif.remaining, LID_FROZEN_REM);
    tif.lid = 1'b0;
    wait_done("t5_done", 100);
    tif.timer_enable = 1'b0;
    tif.mode1        = 1'b0;
    @(negedge clk);

    // Reset mid-run at remaining=12 (normal wash); this run is abandoned,
    // so no expiry is queued for it.
    tif.mode2        = 1'b1;
    tif.phase_sel    = PH_WASH;
    tif.timer_enable = 1'b1;
    repeat (33) @(negedge clk);
    check("t6_pre_reset", tif.remaining, 12);
    #2;
    rst_n            = 1'b0;
    tif.timer_enable = 1'b0;
    #1;
    check("t6_rst_remaining", tif.remaining, 0);
    check("t6_rst_running", tif.running, 0);
    check("t6_rst_done", tif.timer_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tif.timer_enable = 1'b1;
    exp_q.push_back(cyc + 1 + 20 * TICK_DIV);
    @(negedge clk);
    check("t6_reload", tif.remaining, 20);
    wait_done("t6_done", 120);
    tif.timer_enable = 1'b0;
    @(negedge clk);

    check("leftover_done", done_seen.size(), 0);
    check("leftover_expected", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_phase_timer.md
Name: washer_phase_timer

Overview:
- Phase-duration timer that sits directly downstream of the washing-machine controller FSM and closes the loop back to it.
- Consumes the controller's timer_enable, phase_sel, mode and lid signals; produces the one-cycle timer_done pulse the FSM uses to advance SOAK->WASH->RINSE->SPIN->IDLE.
- Divides clk into second ticks, loads a per-mode/per-phase duration, counts down, and exposes remaining time for display.

Parameters:
- TICK_DIV, 50000000, clk cycles per timer tick (1 s at 50 MHz); legal range >= 2.
- CNT_W, 8, width of the remaining-ticks counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- timer_enable  input  1  high while the FSM is in SOAK/WASH/RINSE/SPIN
- phase_sel  input  2  00 soak, 01 wash, 10 rinse, 11 spin
- mode1  input  1  light mode select
- mode2  input  1  normal mode select
- mode3  input  1  heavy mode select
- lid  input  1  1 = lid open
- timer_done  output  1  single-cycle pulse at phase expiry
- remaining  output  CNT_W  ticks left in the current phase
- running  output  1  high while actively counting

Behaviour:
- Reset (async, any time, including mid-countdown):
  - state=IDLE; timer_done=0, remaining=0, running=0.
  - Prescaler, latched mode and prev_phase all cleared.
- Mode priority: mode1 > mode2 > mode3; none asserted -> normal.
  - Mode is latched on the IDLE->RUN load and held until the block returns to IDLE; later mode changes are ignored.
- Duration table, in ticks (soak/wash/rinse/spin):
  - light: 5/10/5/5
  - normal: 10/20/10/10
  - heavy: 20/40/20/15
  - Any table value of 0 is clamped to 1 at load.
- States: IDLE, RUN, DONE.
- IDLE:
  - On timer_enable=1, load remaining=dur(mode, phase_sel), clear the prescaler, record prev_phase=phase_sel, go to RUN.
  - Loaded values are visible the next cycle.
- RUN:
  - running=1; the prescaler counts 0..TICK_DIV-1 and a tick fires on wrap.
  - On each tick, remaining decrements.
  - On a tick with remaining==1: remaining becomes 0, timer_done=1 for exactly that cycle, go to DONE.
  - Latency: the done pulse occurs dur*TICK_DIV cycles after the load edge (no pause).
- DONE:
  - running=0, remaining=0; waits for the FSM to react.
  - A phase_sel change with timer_enable=1 reloads (as in IDLE, mode kept) and returns to RUN.
  - timer_enable=0 returns to IDLE.
- Phase change while in RUN (phase_sel != prev_phase, e.g. after a cancel/restart race): abandon the current count, reload for the new phase, no timer_done.
- timer_enable falling in RUN or DONE:
  - Go to IDLE next cycle and clear remaining and the prescaler.
  - Takes precedence over a same-cycle expiry: no timer_done is issued.
- timer_done is never asserted in consecutive cycles and never while timer_enable=0.
- The prescaler does not run in IDLE or DONE.

Optional Feature:
- Macro: WASHER_TIMER_LID_PAUSE_EN.
- Defined:
  - lid=1 in RUN freezes the prescaler and remaining (running=0, state stays RUN); counting resumes from the frozen values when lid returns to 0.
  - An expiry cannot occur while lid=1.
- Undefined: lid is ignored and the countdown continues regardless; the port remains present.

Decomposition:
- Shared package washer_pkg holds:
  - phase code constants (PH_SOAK, PH_WASH, PH_RINSE, PH_SPIN);
  - mode enum (MODE_LIGHT/NORMAL/HEAVY);
  - timer state enum;
  - duration table and function dur_lookup(mode, phase), reused by the controller for display.
- One sub-module: washer_tick_prescaler (TICK_DIV counter with clear and enable inputs, one-cycle tick output).

Test Plan (TICK_DIV=4 unless noted):
- Load and expire: mode1=1, phase_sel=00, timer_enable 0->1 at cycle 0 -> remaining=5 at cycle 1, decrements every 4 cycles, timer_done high only at cycle 20, remaining=0, state DONE.
- Reload on phase change: after the first expiry, phase_sel->01 -> remaining reloads to 10 (light wash); second timer_done 40 cycles later.
- Default mode: no mode bits, phase_sel=11 -> remaining=10; mode3 raised mid-run has no effect.
- Cancel race: timer_enable drops in the same cycle remaining would go 1->0 -> no timer_done; remaining=0 and IDLE next cycle.
- Lid pause (macro defined): lid=1 for 7 cycles mid-run -> remaining frozen, expiry delayed by exactly 7 cycles. Macro undefined -> expiry cycle unchanged.
- Reset mid-run: rst_n low with remaining=12 -> outputs 0 immediately (asynchronously); after release, a new enable reloads the full duration.
